// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam int          DIV_WIDTH    = 4;
    localparam int          DIV_CNT_W    = $clog2(DIV_WIDTH + 1);
    localparam logic [63:0] DBZ_QUOTIENT = '1;
endpackage

// File: rtl/div_sub_stage.sv
// Combinational (WIDTH+1)-bit borrow-ripple subtractor: full-adder cells,
// inverted subtrahend, carry-in 1. Borrow is the inverted final carry.
module div_sub_stage #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH:0] i_minuend,
    input  logic [WIDTH:0] i_subtrahend,
    output logic [WIDTH:0] o_diff,
    output logic           o_borrow
);
    always_comb begin
        logic [WIDTH+1:0] v_carry;
        v_carry    = '0;
        o_diff     = '0;
        v_carry[0] = 1'b1;
        for (int i = 0; i <= WIDTH; i++) begin
            o_diff[i]      = i_minuend[i] ^ ~i_subtrahend[i] ^ v_carry[i];
            v_carry[i + 1] = (i_minuend[i] & ~i_subtrahend[i]) |
                             (v_carry[i] & (i_minuend[i] ^ ~i_subtrahend[i]));
        end
        o_borrow = ~v_carry[WIDTH + 1];
    end
endmodule

// File: rtl/seq_restoring_div.sv
// Multi-cycle restoring divider, one shift-and-subtract step per clock.
// Optional two's-complement operands via the DIV_SIGNED_EN macro.
module seq_restoring_div
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    div_state_t       r_state, w_state_next;
    logic [WIDTH-1:0] r_rem, r_quo, r_div;
    logic [WIDTH-1:0] r_quotient, r_remainder;
    logic             r_dbz;
    logic [CNT_W-1:0] r_cnt;

    logic             w_accept, w_release, w_last, w_div_zero;
    logic [WIDTH:0]   w_diff;
    logic             w_borrow;
    logic [WIDTH-1:0] w_rem_step, w_quo_step, w_quo_final, w_rem_final;
    logic [WIDTH-1:0] w_op_a, w_op_b;

    assign w_accept   = in_valid && in_ready;
    assign w_release  = out_valid && out_ready;
    assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));
    assign w_div_zero = (divisor == '0);

`ifdef DIV_SIGNED_EN
    logic r_neg_q, r_neg_r;
    assign w_op_a      = dividend[WIDTH-1] ? -dividend : dividend;
    assign w_op_b      = divisor[WIDTH-1]  ? -divisor  : divisor;
    assign w_quo_final = r_neg_q ? -w_quo_step : w_quo_step;
    assign w_rem_final = r_neg_r ? -w_rem_step : w_rem_step;
`else
    assign w_op_a      = dividend;
    assign w_op_b      = divisor;
    assign w_quo_final = w_quo_step;
    assign w_rem_final = w_rem_step;
`endif

    div_sub_stage #(.WIDTH(WIDTH)) u_sub (
        .i_minuend    ({r_rem, r_quo[WIDTH-1]}),
        .i_subtrahend ({1'b0, r_div}),
        .o_diff       (w_diff),
        .o_borrow     (w_borrow)
    );

    // A borrow restores the shifted partial remainder instead of the difference.
    assign w_rem_step = w_borrow ? {r_rem[WIDTH-2:0], r_quo[WIDTH-1]} : w_diff[WIDTH-1:0];
    assign w_quo_step = {r_quo[WIDTH-2:0], ~w_borrow};

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_next = w_div_zero ? DONE : CALC;
            CALC:    if (w_last) w_state_next = DONE;
            DONE:    if (w_release) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == IDLE);
        out_valid = (r_state == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rem       <= '0;
            r_quo       <= '0;
            r_div       <= '0;
            r_cnt       <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
`ifdef DIV_SIGNED_EN
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
`endif
        end else if (w_accept) begin
            if (w_div_zero) begin
                r_quotient  <= DBZ_QUOTIENT[WIDTH-1:0];
                r_remainder <= dividend;
                r_dbz       <= 1'b1;
            end else begin
                r_rem <= '0;
                r_quo <= w_op_a;
                r_div <= w_op_b;
                r_cnt <= '0;
`ifdef DIV_SIGNED_EN
                r_neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                r_neg_r <= dividend[WIDTH-1];
`endif
            end
        end else if (r_state == CALC) begin
            r_rem <= w_rem_step;
            r_quo <= w_quo_step;
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
                r_quotient  <= w_quo_final;
                r_remainder <= w_rem_final;
                r_dbz       <= 1'b0;
            end
        end
    end

    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_dbz;
endmodule

// File: tb/tb_seq_restoring_div.sv
// Directed self-checking bench for seq_restoring_div at WIDTH=4.
module tb_seq_restoring_div;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] dividend = '0;
    logic [3:0] divisor = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [3:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    seq_restoring_div #(.WIDTH(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    // Accept one operand pair and wait (bounded) for out_valid.
    // lat counts clock edges including the accept edge.
    task automatic run_op(input logic [3:0] a, input logic [3:0] b,
                          output logic [3:0] q, output logic [3:0] r,
                          output logic z, output int lat);
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        q = quotient;
        r = remainder;
        z = div_by_zero;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({in_ready, out_valid, quotient, remainder, div_by_zero} !== {1'b1, 1'b0, 4'd0, 4'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state: rdy=%b vld=%b q=%0d r=%0d z=%b, required rdy=1 vld=0 q=0 r=0 z=0",
                     in_ready, out_valid, quotient, remainder, div_by_zero);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_div_by_zero();
        logic [3:0] q, r; logic z; int lat;
        run_op(4'd7, 4'd0, q, r, z, lat);
        n_cmp++;
        if ({q, r, z} !== {4'd15, 4'd7, 1'b1} || lat !== 1) begin
            n_fail++;
            $display("FAIL dbz_7_0: q=%0d r=%0d z=%b lat=%0d, required q=15 r=7 z=1 lat=1", q, r, z, lat);
        end
        @(posedge clk); #1;
    endtask

`ifndef DIV_SIGNED_EN
    task automatic test_basic();
        logic [3:0] q, r; logic z; int lat;
        run_op(4'd13, 4'd3, q, r, z, lat);
        n_cmp++;
        if ({q, r, z} !== {4'd4, 4'd1, 1'b0} || lat !== 5) begin
            n_fail++;
            $display("FAIL div_13_3: q=%0d r=%0d z=%b lat=%0d, required q=4 r=1 z=0 lat=5", q, r, z, lat);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL post_handshake: vld=%b rdy=%b, required vld=0 rdy=1", out_valid, in_ready);
        end
        run_op(4'd15, 4'd1, q, r, z, lat);
        n_cmp++;
        if ({q, r, z} !== {4'd15, 4'd0, 1'b0} || lat !== 5) begin
            n_fail++;
            $display("FAIL div_15_1: q=%0d r=%0d z=%b lat=%0d, required q=15 r=0 z=0 lat=5", q, r, z, lat);
        end
        @(posedge clk); #1;
        run_op(4'd2, 4'd9, q, r, z, lat);
        n_cmp++;
        if ({q, r, z} !== {4'd0, 4'd2, 1'b0} || lat !== 5) begin
            n_fail++;
            $display("FAIL div_2_9: q=%0d r=%0d z=%b lat=%0d, required q=0 r=2 z=0 lat=5", q, r, z, lat);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        logic [3:0] q, r; logic z; int lat;
        out_ready = 1'b0;
        run_op(4'd13, 4'd3, q, r, z, lat);
        n_cmp++;
        if ({q, r, z} !== {4'd4, 4'd1, 1'b0} || lat !== 5) begin
            n_fail++;
            $display("FAIL bp_result: q=%0d r=%0d z=%b lat=%0d, required q=4 r=1 z=0 lat=5", q, r, z, lat);
        end
        for (int i = 0; i < 3; i++) begin
            dividend = 4'd2;
            divisor  = 4'd1;
            in_valid = 1'b1;
            @(posedge clk); #1;
            n_cmp++;
            if ({out_valid, in_ready, quotient, remainder, div_by_zero} !== {1'b1, 1'b0, 4'd4, 4'd1, 1'b0}) begin
                n_fail++;
                $display("FAIL bp_hold_%0d: vld=%b rdy=%b q=%0d r=%0d z=%b, required vld=1 rdy=0 q=4 r=1 z=0",
                         i, out_valid, in_ready, quotient, remainder, div_by_zero);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release: vld=%b rdy=%b, required vld=0 rdy=1", out_valid, in_ready);
        end
        repeat (6) @(posedge clk);
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_not_queued: vld=%b rdy=%b, required vld=0 rdy=1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid_calc();
        logic [3:0] q, r; logic z; int lat;
        dividend = 4'd13;
        divisor  = 4'd3;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        n_cmp++;
        if ({in_ready, out_valid, quotient, remainder, div_by_zero} !== {1'b1, 1'b0, 4'd0, 4'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_mid_calc: rdy=%b vld=%b q=%0d r=%0d z=%b, required rdy=1 vld=0 q=0 r=0 z=0",
                     in_ready, out_valid, quotient, remainder, div_by_zero);
        end
        run_op(4'd9, 4'd4, q, r, z, lat);
        n_cmp++;
        if ({q, r, z} !== {4'd2, 4'd1, 1'b0} || lat !== 5) begin
            n_fail++;
            $display("FAIL div_9_4_after_reset: q=%0d r=%0d z=%b lat=%0d, required q=2 r=1 z=0 lat=5", q, r, z, lat);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_sweep();
        logic [3:0] q, r; logic z; int lat;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                run_op(4'(a), 4'(b), q, r, z, lat);
                n_cmp++;
                if (b == 0) begin
                    if ({q, r, z} !== {4'd15, 4'(a), 1'b1} || lat !== 1) begin
                        n_fail++;
                        $display("FAIL sweep_%0d_%0d: q=%0d r=%0d z=%b lat=%0d, required q=15 r=%0d z=1 lat=1",
                                 a, b, q, r, z, lat, a);
                    end
                end else if ((int'(q) * b + int'(r)) != a || int'(r) >= b || z !== 1'b0 || lat !== 5) begin
                    n_fail++;
                    $display("FAIL sweep_%0d_%0d: q=%0d r=%0d z=%b lat=%0d, required q*d+r=%0d r<%0d z=0 lat=5",
                             a, b, q, r, z, lat, a, b);
                end
                @(posedge clk); #1;
            end
        end
    endtask
`else
    task automatic test_signed();
        logic [3:0] q, r; logic z; int lat;
        run_op(4'b1001, 4'd2, q, r, z, lat);
        n_cmp++;
        if ({q, r, z} !== {4'b1101, 4'b1111, 1'b0} || lat !== 5) begin
            n_fail++;
            $display("FAIL sdiv_m7_2: q=%b r=%b z=%b lat=%0d, required q=1101 r=1111 z=0 lat=5", q, r, z, lat);
        end
        @(posedge clk); #1;
        run_op(4'b1000, 4'b1111, q, r, z, lat);
        n_cmp++;
        if ({q, r, z} !== {4'b1000, 4'b0000, 1'b0} || lat !== 5) begin
            n_fail++;
            $display("FAIL sdiv_m8_m1: q=%b r=%b z=%b lat=%0d, required q=1000 r=0000 z=0 lat=5", q, r, z, lat);
        end
        @(posedge clk); #1;
        run_op(4'd7, 4'b1110, q, r, z, lat);
        n_cmp++;
        if ({q, r, z} !== {4'b1101, 4'b0001, 1'b0} || lat !== 5) begin
            n_fail++;
            $display("FAIL sdiv_7_m2: q=%b r=%b z=%b lat=%0d, required q=1101 r=0001 z=0 lat=5", q, r, z, lat);
        end
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        test_reset();
        test_div_by_zero();
`ifndef DIV_SIGNED_EN
        test_basic();
        test_backpressure();
        test_reset_mid_calc();
        test_sweep();
`else
        test_signed();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
